mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_wait_counter.sv | 43 ++++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_t     : 2-bit encoding of the arbiter FSM states
//   TIMEOUT_DEFAULT : default number of wait cycles before a request aborts
//   WAIT_W          : width of the wait counter
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int WAIT_W          = 8;

endpackage

// File: rtl/arb_wait_counter.sv
// ---------------------------------------------------------------------------
// arb_wait_counter
// Counts the cycles the shared memory port has been waiting for mem_ack and
// flags when the abort threshold is reached.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   i_clear    : a new grant is being issued, restart the count
//   i_inc      : mem_req is high and mem_ack is low this cycle
//   o_terminal : count has reached TIMEOUT
// ---------------------------------------------------------------------------
module arb_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_terminal
);

    localparam logic [WAIT_W-1:0] TERM_COUNT = TIMEOUT[WAIT_W-1:0];

    logic [WAIT_W-1:0] r_count;

    // Clear has priority so a back-to-back grant always starts from zero.
    // The count saturates at the terminal value so it can never wrap around
    // and silently miss the abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != TERM_COUNT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == TERM_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates one shared memory port between the fetch stage and the memory
// stage. The data side wins ties; a completion hands the port straight to
// the other side when it is waiting.
//   clk, rst                         : clock, asynchronous active-low reset
//   if_req/if_addr/if_flush          : fetch request, address, flush
//   if_valid/if_rdata                : fetch completion pulse and data
//   dm_req/dm_we/dm_addr/dm_wdata    : memory-stage request
//   dm_valid/dm_rdata                : memory-stage completion pulse and data
//   mem_req/mem_we/mem_addr/mem_wdata: registered shared-port request
//   mem_ack/mem_rdata                : shared-port completion and read data
//   stall_f/stall_m                  : pipeline stall requests
//   err                              : pulse when a request is aborted
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_f,
    output logic        stall_m,
    output logic        err
);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_cancel;
    logic        r_ready;
    logic        w_terminal;
    logic        w_done;
    logic        w_timeout;
    logic        w_finish;
    logic        w_cancelled;
    logic        w_if_pending;
    logic        w_grant_i;
    logic        w_grant_d;

    assign w_if_pending = if_req & ~if_flush;
    assign w_done       = r_mem_req & mem_ack;
    assign w_timeout    = r_mem_req & ~mem_ack & w_terminal;
    assign w_finish     = w_done | w_timeout;
    // A flush arriving in the completion cycle itself also cancels the fetch.
    assign w_cancelled  = r_cancel | if_flush;

    arb_wait_counter #(
        .TIMEOUT    (TIMEOUT)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_grant_i | w_grant_d),
        .i_inc      (r_mem_req & ~mem_ack),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_ready holds off grants for the first edge after reset release.
    // A cancelled fetch always falls back to IDLE rather than chaining into a
    // data grant, so the data request is re-arbitrated from a clean state.
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ready) begin
                    if (dm_req) begin
                        w_next_state = ST_SERVE_D;
                        w_grant_d    = 1'b1;
                    end else if (w_if_pending) begin
                        w_next_state = ST_SERVE_I;
                        w_grant_i    = 1'b1;
                    end
                end
            end
            ST_SERVE_I: begin
                if (w_timeout) begin
                    w_next_state = ST_IDLE;
                end else if (w_done) begin
                    if (!w_cancelled && dm_req) begin
                        w_next_state = ST_SERVE_D;
                        w_grant_d    = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_SERVE_D: begin
                if (w_timeout) begin
                    w_next_state = ST_IDLE;
                end else if (w_done) begin
                    if (w_if_pending) begin
                        w_next_state = ST_SERVE_I;
                        w_grant_i    = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Port registers only change on a grant, so they hold steady while the
    // memory is still working on the current transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cancel    <= 1'b0;
        end else begin
            r_ready   <= 1'b1;
            r_mem_req <= (w_next_state != ST_IDLE);
            if (w_grant_d) begin
                r_mem_we    <= dm_we;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
            end else if (w_grant_i) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
            end
            if (w_grant_i || w_grant_d) begin
                r_cancel <= 1'b0;
            end else if ((r_state == ST_SERVE_I) && (w_next_state == ST_SERVE_I)) begin
                r_cancel <= r_cancel | if_flush;
            end else begin
                r_cancel <= 1'b0;
            end
        end
    end

    // Completion and abort pulses are combinational from mem_ack and the
    // wait counter; an abort returns zero data.
    assign if_valid  = (r_state == ST_SERVE_I) & w_finish & ~w_cancelled;
    assign if_rdata  = (if_valid & w_done) ? mem_rdata : 32'h0;
    assign dm_valid  = (r_state == ST_SERVE_D) & w_finish;
    assign dm_rdata  = (dm_valid & w_done & ~r_mem_we) ? mem_rdata : 32'h0;
    assign err       = w_timeout;

    assign stall_f   = if_req & ~if_flush & ~if_valid;
    assign stall_m   = dm_req & ~dm_valid;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
